// File: rtl/div_meter_pkg.sv
// Shared definitions for the divided-clock period meter.
// Holds the FSM state encoding, the divide-ratio select encoding and the
// expected-period helper (2 << sel), plus the default counter width.
package div_meter_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } meter_state_e;

  typedef enum logic [1:0] {
    SEL_DIV2  = 2'd0,
    SEL_DIV4  = 2'd1,
    SEL_DIV8  = 2'd2,
    SEL_DIV16 = 2'd3
  } div_sel_e;

  // Expected period in clk cycles for a given ratio select.
  function automatic int unsigned exp_period(input logic [1:0] sel);
    return 32'd2 << sel;
  endfunction

endpackage

// File: rtl/div_sync_edge.sv
// Input conditioning for the period meter.
// SYNC_STAGES-deep synchronizer on the asynchronous sig_i, an optional
// 2-sample stability filter (build with DIV_GLITCH_FILTER_EN defined), then an
// edge-history flop producing single-cycle rise/fall pulses.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   sig_i          : asynchronous signal under measurement
//   level_o        : conditioned (synchronized / filtered) level
//   rise_o, fall_o : one-cycle edge pulses on level_o
module div_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   lvl;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
  end

`ifdef DIV_GLITCH_FILTER_EN
  // A new level is accepted only once two consecutive samples agree, so a
  // single-cycle pulse never reaches the edge detector.
  logic samp_q, filt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      samp_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      samp_q <= sync_q[SYNC_STAGES-1];
      if (sync_q[SYNC_STAGES-1] == samp_q) filt_q <= samp_q;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hist_q <= 1'b0;
    else          hist_q <= lvl;
  end

  assign level_o = lvl;
  assign rise_o  = lvl & ~hist_q;
  assign fall_o  = ~lvl & hist_q;

endmodule

// File: rtl/div_period_meter.sv
// Divided-clock period meter.
// Measures period and high time of a slow divided clock in clk cycles,
// checks the period against 2 << sel and reports lock after LOCK_COUNT
// consecutive matches. Optional glitch filter: DIV_GLITCH_FILTER_EN.
// Ports:
//   clk_i, rst_n_i   : clock, async active-low reset
//   ena_i            : enable; low returns to IDLE and clears lock/overflow
//   sig_in_i         : asynchronous divided clock under measurement
//   sel_i            : expected ratio (0:/2 1:/4 2:/8 3:/16)
//   period_o         : last measured period
//   high_time_o      : last measured high time
//   meas_valid_o     : one-cycle pulse on each result update
//   locked_o         : LOCK_COUNT consecutive matching periods
//   overflow_o       : sticky, counter saturated without a rising edge
module div_period_meter
  import div_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             ena_i,
  input  logic             sig_in_i,
  input  logic [1:0]       sel_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_time_o,
  output logic             meas_valid_o,
  output logic             locked_o,
  output logic             overflow_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rise, fall;
  meter_state_e     state_q;
  logic [CNT_W-1:0] cnt_q, hold_q, period_q, high_q;
  logic             valid_q, locked_q, ovf_q;
  logic [3:0]       match_q;
  logic [1:0]       sel_q;

  div_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .sig_i   (sig_in_i),
    .level_o (),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      match_q  <= '0;
      sel_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      sel_q   <= sel_i;
      if (!ena_i) begin
        // period/high_time intentionally keep their last values
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        hold_q   <= '0;
        match_q  <= '0;
        locked_q <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        // Lock bookkeeping runs on the cycle the result is visible; a sel
        // change takes priority over a simultaneous match.
        locked_q <= (match_q == 4'(LOCK_COUNT));
        if (sel_i != sel_q) begin
          match_q  <= '0;
          locked_q <= 1'b0;
        end else if (valid_q) begin
          if (period_q == CNT_W'(exp_period(sel_i))) begin
            if (match_q != 4'(LOCK_COUNT)) match_q <= match_q + 4'd1;
          end else begin
            match_q  <= '0;
            locked_q <= 1'b0;
          end
        end

        unique case (state_q)
          ST_IDLE: begin
            cnt_q   <= '0;
            state_q <= ST_ARM;
          end
          ST_ARM: begin
            cnt_q <= '0;
            if (rise) begin
              cnt_q   <= CNT_W'(1);
              hold_q  <= '0;
              state_q <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            // A rise on the saturation cycle still counts as a valid period.
            if (rise) begin
              period_q <= cnt_q;
              high_q   <= hold_q;
              valid_q  <= 1'b1;
              ovf_q    <= 1'b0;
              cnt_q    <= CNT_W'(1);
              hold_q   <= '0;
            end else begin
              if (fall) hold_q <= cnt_q;
              if (cnt_q == CNT_MAX) begin
                ovf_q    <= 1'b1;
                match_q  <= '0;
                locked_q <= 1'b0;
                state_q  <= ST_ARM;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign period_o     = period_q;
  assign high_time_o  = high_q;
  assign meas_valid_o = valid_q;
  assign locked_o     = locked_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_div_period_meter.sv
// Scoreboard bench for div_period_meter (CNT_W = 8 so saturation is reachable).
// A reference model watches the driven waveform at clock edges, derives
// periods/high times from the rising/falling edge times and pushes expected
// results; a monitor pops one on every meas_valid and checks lock status.
module tb_div_period_meter;
  localparam int CNT_W = 8;
  localparam int LOCK  = 4;
  localparam int MAXC  = 255;

  logic             clk = 1'b0, rst_n = 1'b0, ena = 1'b0, sig = 1'b0;
  logic [1:0]       sel = 2'd2;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, locked, overflow;

  div_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_COUNT(LOCK)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena), .sig_in_i(sig), .sel_i(sel),
    .period_o(period), .high_time_o(high_time), .meas_valid_o(meas_valid),
    .locked_o(locked), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  typedef struct { int per; int hi; bit brk; } meas_t;
  meas_t q[$];

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: edge times of the (optionally filtered) input level.
  int cyc = 0, last_rise = 0, hi = 0;
  bit prev_s = 0, f = 0, f_new, armed = 0, brk = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
`ifdef DIV_GLITCH_FILTER_EN
      f_new = (sig == prev_s) ? sig : f;
`else
      f_new = sig;
`endif
      prev_s = sig;
      if (!ena) begin
        armed = 0;
        brk   = 1;
      end else begin
        if (armed && (cyc - last_rise) > MAXC) begin
          armed = 0;
          brk   = 1;
        end
        if (f_new && !f) begin
          if (armed) begin
            q.push_back('{cyc - last_rise, hi, brk});
            brk = 0;
          end
          armed     = 1;
          last_rise = cyc;
          hi        = 0;
        end else if (!f_new && f && armed) begin
          hi = cyc - last_rise;
        end
      end
      f = f_new;
    end
  end

  // Monitor: pop on each result pulse; lock expected after LOCK matches in a row.
  int run = 0;
  logic [1:0] last_sel = 2'd2;
  always @(negedge clk) begin
    if (rst_n) begin
      bit popped;
      meas_t e;
      popped = 0;
      if (meas_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_meas_valid: got period %0d, expected no result", period);
        end else begin
          e = q.pop_front();
          popped = 1;
          if (e.brk) run = 0;
          check("period", int'(period), e.per);
          check("high_time", int'(high_time), e.hi);
          check("overflow_at_valid", int'(overflow), 0);
          check("locked_at_valid", int'(locked), (run >= LOCK) ? 1 : 0);
        end
      end
      if (!ena || sel != last_sel) run = 0;
      else if (popped) run = (e.per == (2 << sel)) ? run + 1 : 0;
      last_sel = sel;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wave(int per, int h, int n);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < per; j++) begin
        @(negedge clk);
        sig = (j < h);
      end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high_time), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_overflow", int'(overflow), 0);
    @(negedge clk); rst_n = 1'b1; ena = 1'b1;
    tick(3);

    // clk/8 with matching select, then a select change while locked
    sel = 2'd2;
    wave(8, 4, 7);
    check("lock_div8", int'(locked), 1);
    fork
      wave(8, 4, 6);
      begin tick(3); sel = 2'd3; tick(1); check("unlock_on_sel", int'(locked), 0); end
    join
    check("no_lock_sel3", int'(locked), 0);
    fork
      wave(8, 4, 7);
      begin tick(3); sel = 2'd2; end
    join
    check("relock_div8", int'(locked), 1);

    // Saturation: one rise then silence, then clk/4
    sel = 2'd1;
    wave(4, 2, 1);
    tick(300);
    check("overflow_set", int'(overflow), 1);
    check("overflow_unlocked", int'(locked), 0);
    wave(4, 2, 8);
    check("overflow_cleared", int'(overflow), 0);
    check("lock_div4", int'(locked), 1);

    // Boundary: 255-cycle period measures, 256-cycle period overflows
    wave(255, 10, 3);
    wave(256, 10, 3);
    tick(300);
    check("overflow_256", int'(overflow), 1);

    // ena dropped mid-measurement of clk/16
    sel = 2'd3;
    wave(16, 8, 7);
    check("lock_div16", int'(locked), 1);
    for (int j = 0; j < 12; j++) begin @(negedge clk); sig = (j < 8); end
    ena = 1'b0;
    tick(1);
    check("ena_off_locked", int'(locked), 0);
    check("ena_off_valid", int'(meas_valid), 0);
    check("ena_off_period_hold", int'(period), 16);
    tick(10);
    ena = 1'b1;
    tick(10);
    wave(16, 8, 6);
    check("lock_after_ena", int'(locked), 1);

    // Single-cycle glitch in the low phase of clk/16
    for (int j = 0; j < 16; j++) begin @(negedge clk); sig = (j < 8) || (j == 11); end
    wave(16, 8, 1);
`ifdef DIV_GLITCH_FILTER_EN
    check("glitch_locked", int'(locked), 1);
`else
    check("glitch_locked", int'(locked), 0);
`endif
    wave(16, 8, 3);

    // Randomized segments
    for (int s = 0; s < 20; s++) begin
      int per, h, n;
      if ($urandom_range(0, 1) == 0) per = 2 << $urandom_range(0, 3);
      else                           per = $urandom_range(2, 40);
      h = $urandom_range(1, per - 1);
      n = $urandom_range(2, 7);
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
      wave(per, h, n);
      if ($urandom_range(0, 7) == 0) begin sig = 1'b0; tick($urandom_range(250, 262)); end
    end

    // Drain outstanding results
    sig = 1'b0;
    for (int t = 0; t < 40 && q.size() != 0; t++) tick(1);
    tick(10);
    check("scoreboard_drained", q.size(), 0);

    // Asynchronous reset mid-period
    sel = 2'd3;
    wave(16, 8, 3);
    for (int j = 0; j < 5; j++) begin @(negedge clk); sig = 1'b1; end
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_period", int'(period), 0);
    check("async_rst_high", int'(high_time), 0);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_valid", int'(meas_valid), 0);
    check("async_rst_overflow", int'(overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
